// File: rtl/lfsr_sequence_checker_pkg.sv
// Shared LFSR definitions for the random-number generator and its receive-side checker.
package lfsr_sequence_checker_pkg;

  localparam int unsigned LFSR_WIDTH = 32;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 32'hF23A_27BB;

  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_nxt(input logic [LFSR_WIDTH-1:0] w);
    return {w[LFSR_WIDTH-2:0], w[TAP_A] ^ w[TAP_B] ^ w[TAP_C] ^ w[TAP_D]};
  endfunction

endpackage

// File: rtl/lfsr_sequence_checker_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lfsr_sequence_checker.sv
// Receive-side LFSR stream checker: hunts for a seed, verifies a run of predictions,
// then tracks lock and counts mismatches on the free-running prediction.
module lfsr_sequence_checker
  import lfsr_sequence_checker_pkg::*;
#(
  parameter int unsigned LOCK_THRESH   = 8,
  parameter int unsigned UNLOCK_THRESH = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [LFSR_WIDTH-1:0] in_data,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  word_count
);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_e;

  localparam int unsigned GW = $clog2(LOCK_THRESH + 1);
  localparam int unsigned BW = $clog2(UNLOCK_THRESH + 1);

  state_e                state_q, state_d;
  logic [LFSR_WIDTH-1:0] pred_q, pred_d;
  logic [GW-1:0]         good_q, good_d, good_inc;
  logic [BW-1:0]         bad_q, bad_d, bad_inc;
  logic                  err_pulse_q, err_pulse_d;
  logic                  match, err_inc, word_inc;

  assign match    = (in_data == pred_q);
  assign good_inc = good_q + GW'(1);
  assign bad_inc  = bad_q + BW'(1);

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    good_d      = good_q;
    bad_d       = bad_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    word_inc    = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          // All-zero is the LFSR lock-up word and cannot seed a prediction.
          if (in_data != '0) begin
            pred_d  = lfsr_nxt(in_data);
            good_d  = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          pred_d = lfsr_nxt(in_data);
          if (match) begin
            good_d = good_inc;
            if (good_inc == GW'(LOCK_THRESH)) begin
              bad_d   = '0;
              state_d = LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          // Free-run the prediction so a corrupted word never re-seeds it.
          pred_d   = lfsr_nxt(pred_q);
          word_inc = 1'b1;
          if (match) begin
            bad_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            bad_d       = bad_inc;
            if (bad_inc == BW'(UNLOCK_THRESH)) begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q     <= HUNT;
      pred_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rstnn (rstnn),
    .clr   (clear),
    .inc   (err_inc),
    .count (err_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_word_cnt (
    .clk   (clk),
    .rstnn (rstnn),
    .clr   (clear),
    .inc   (word_inc),
    .count (word_count)
  );

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Scoreboard bench for lfsr_sequence_checker: a behavioural model predicts each cycle's
// outputs, which are queued on drive and compared one cycle later.
module tb_lfsr_sequence_checker;

  logic        clk = 1'b0;
  logic        rstnn, clear, in_valid;
  logic [31:0] in_data;
  logic        locked, err_pulse;
  logic [15:0] err_count, word_count;
  logic        s_locked, s_err_pulse;
  logic [3:0]  s_err_count, s_word_count;

  always #5 clk = ~clk;

  lfsr_sequence_checker dut (
    .clk        (clk),
    .rstnn      (rstnn),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .word_count (word_count)
  );

  lfsr_sequence_checker #(.LOCK_THRESH(8), .UNLOCK_THRESH(32), .CNT_WIDTH(4)) dut_sat (
    .clk        (clk),
    .rstnn      (rstnn),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .locked     (s_locked),
    .err_pulse  (s_err_pulse),
    .err_count  (s_err_count),
    .word_count (s_word_count)
  );

  typedef struct packed {
    logic        lck;
    logic        pulse;
    logic [15:0] errs;
    logic [15:0] words;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state (defaults: lock after 8 good, unlock after 4 bad).
  int          m_state;
  logic [31:0] m_pred;
  int          m_good, m_bad, m_errs, m_words;
  logic        m_pulse;
  logic [31:0] g;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gen_next(input logic [31:0] w);
    logic fb;
    fb = w[31] ^ w[21] ^ w[1] ^ w[0];
    return (w << 1) | {31'd0, fb};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pred = '0; m_good = 0; m_bad = 0;
    m_errs = 0; m_words = 0; m_pulse = 1'b0;
    sb_q.delete();
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic clr);
    exp_t e;
    bit   ei, wi;
    ei = 0; wi = 0;
    in_valid = v; in_data = d; clear = clr;
    m_pulse = 1'b0;
    if (v) begin
      if (m_state == 0) begin
        if (d != 32'd0) begin
          m_pred = gen_next(d); m_good = 0; m_state = 1;
        end
      end else if (m_state == 1) begin
        if (d == m_pred) begin
          m_good++;
          if (m_good == 8) begin m_state = 2; m_bad = 0; end
        end else begin
          m_good = 0;
        end
        m_pred = gen_next(d);
      end else begin
        wi = 1;
        if (d == m_pred) m_bad = 0;
        else begin
          ei = 1; m_pulse = 1'b1; m_bad++;
          if (m_bad == 4) m_state = 0;
        end
        m_pred = gen_next(m_pred);
      end
    end
    if (clr) begin
      m_errs = 0; m_words = 0;
    end else begin
      if (ei && m_errs < 65535) m_errs++;
      if (wi && m_words < 65535) m_words++;
    end
    sb_q.push_back('{lck: (m_state == 2), pulse: m_pulse, errs: 16'(m_errs), words: 16'(m_words)});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("locked", 32'(locked), 32'(e.lck));
    check_eq("err_pulse", 32'(err_pulse), 32'(e.pulse));
    check_eq("err_count", 32'(err_count), 32'(e.errs));
    check_eq("word_count", 32'(word_count), 32'(e.words));
  endtask

  task automatic send_good();
    drive(1'b1, g, 1'b0);
    g = gen_next(g);
  endtask

  task automatic send_bad(input logic [31:0] flip);
    drive(1'b1, g ^ flip, 1'b0);
    g = gen_next(g);
  endtask

  task automatic do_reset();
    rstnn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_err_pulse", 32'(err_pulse), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    rstnn = 1'b1;
  endtask

  initial begin
    int lock_at;
    int nvalid;

    // Clean generator stream: lock one clock after the ninth word.
    do_reset();
    g = 32'hF23A_27BB;
    lock_at = 0;
    for (int i = 1; i <= 12; i++) begin
      send_good();
      if (locked && lock_at == 0) lock_at = i;
    end
    check_eq("s1_lock_word", 32'(lock_at), 32'd9);
    check_eq("s1_err_count", 32'(err_count), 32'd0);

    // Single corrupted word while locked: one pulse, no re-seed.
    send_bad(32'h1);
    check_eq("s2_pulse", 32'(err_pulse), 32'd1);
    send_good();
    check_eq("s2_pulse_gone", 32'(err_pulse), 32'd0);
    check_eq("s2_err_count", 32'(err_count), 32'd1);
    check_eq("s2_locked", 32'(locked), 32'd1);
    send_good();

    // Source switches seed: unlock after 4 bad words, relock after 9 more.
    drive(1'b0, 32'hDEAD_BEEF, 1'b1);
    g = 32'h1234_5678;
    repeat (4) send_good();
    check_eq("s3_unlocked", 32'(locked), 32'd0);
    check_eq("s3_err_count", 32'(err_count), 32'd4);
    for (int i = 1; i <= 9; i++) begin
      send_good();
      if (i == 8) check_eq("s3_not_yet", 32'(locked), 32'd0);
    end
    check_eq("s3_relocked", 32'(locked), 32'd1);

    // Random idle gaps: lock time counts valid words only.
    do_reset();
    g = 32'hF23A_27BB;
    lock_at = 0;
    nvalid = 0;
    for (int i = 0; i < 14; i++) begin
      int gap;
      gap = int'($urandom_range(0, 5));
      for (int k = 0; k < gap; k++) drive(1'b0, $urandom, 1'b0);
      send_good();
      nvalid++;
      if (locked && lock_at == 0) lock_at = nvalid;
    end
    check_eq("s4_lock_word", 32'(lock_at), 32'd9);
    check_eq("s4_err_count", 32'(err_count), 32'd0);

    // All-zero words in HUNT, then clear colliding with a mismatch.
    do_reset();
    repeat (3) drive(1'b1, 32'd0, 1'b0);
    check_eq("s5_zero_hunt", 32'(locked), 32'd0);
    g = 32'hF23A_27BB;
    repeat (9) send_good();
    drive(1'b1, g ^ 32'h8000_0000, 1'b1);
    g = gen_next(g);
    check_eq("s5_clear_wins", 32'(err_count), 32'd0);
    check_eq("s5_pulse", 32'(err_pulse), 32'd1);

    // Narrow counters saturate; async reset mid-stream clears everything.
    do_reset();
    g = 32'hF23A_27BB;
    repeat (9) send_good();
    check_eq("s6_sat_locked", 32'(s_locked), 32'd1);
    repeat (20) send_bad(32'h1);
    check_eq("s6_sat_err", 32'(s_err_count), 32'd15);
    check_eq("s6_sat_words", 32'(s_word_count), 32'd15);
    check_eq("s6_sat_still_locked", 32'(s_locked), 32'd1);
    in_valid = 1'b1; in_data = g;
    #3;
    rstnn = 1'b0;
    #1;
    check_eq("s6_async_locked", 32'(s_locked), 32'd0);
    check_eq("s6_async_pulse", 32'(s_err_pulse), 32'd0);
    check_eq("s6_async_err", 32'(s_err_count), 32'd0);
    check_eq("s6_async_words", 32'(s_word_count), 32'd0);
    check_eq("s6_async_main_err", 32'(err_count), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rstnn = 1'b1;
    model_reset();
    g = 32'hF23A_27BB;
    for (int i = 1; i <= 9; i++) begin
      send_good();
      if (i == 8) check_eq("s6_no_partial", 32'(locked), 32'd0);
    end
    check_eq("s6_relock", 32'(locked), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
